// File: rtl/pipeline_mem_skid.sv
// Memory-to-Writeback pipeline stage. A 2-entry skid buffer lets Writeback stall the pipe
// while in_ready stays a function of registered state only.
module pipeline_mem_skid #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 4,
    parameter int unsigned WEN_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WEN_W-1:0]  wEn_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WEN_W-1:0]  wEn_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        occupancy,
    input  logic [RD_W-1:0]   query_rd,
    output logic              query_hit
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e            state;
    logic              main_valid;
    logic [WEN_W-1:0]  main_wen;
    logic [RD_W-1:0]   main_rd;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [WEN_W-1:0]  skid_wen;
    logic [RD_W-1:0]   skid_rd;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic pop;

    assign in_ready  = (state != StTwo);
    assign out_valid = (state != StEmpty);
    assign occupancy = state;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StEmpty;
            main_valid <= 1'b0;
            main_wen   <= '0;
            main_rd    <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_wen   <= '0;
            skid_rd    <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            // Payloads are kept so rd_out/data_out still show the last loaded entry.
            state      <= StEmpty;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (state)
                StEmpty: begin
                    if (accept) begin
                        main_valid <= 1'b1;
                        main_wen   <= wEn_in;
                        main_rd    <= rd_in;
                        main_data  <= data_in;
                        state      <= StOne;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_wen  <= wEn_in;
                        main_rd   <= rd_in;
                        main_data <= data_in;
                    end else if (accept) begin
                        skid_valid <= 1'b1;
                        skid_wen   <= wEn_in;
                        skid_rd    <= rd_in;
                        skid_data  <= data_in;
                        state      <= StTwo;
                    end else if (pop) begin
                        main_valid <= 1'b0;
                        state      <= StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        main_wen   <= skid_wen;
                        main_rd    <= skid_rd;
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                        state      <= StOne;
                    end
                end
                default: begin
                    state      <= StEmpty;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

    assign wEn_out  = main_valid ? main_wen : '0;
    assign rd_out   = main_rd;
    assign data_out = main_data;

    assign query_hit = (main_valid && (main_wen != '0) && (main_rd == query_rd)) ||
                       (skid_valid && (skid_wen != '0) && (skid_rd == query_rd));

endmodule

// File: tb/tb_pipeline_mem_skid.sv
// Directed bench for pipeline_mem_skid: a table of per-cycle vectors plus a streaming
// sequence with irregular back-pressure checked against an in-order queue.
module tb_pipeline_mem_skid;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, query_hit;
    logic [1:0]  wEn_in, wEn_out, occupancy;
    logic [3:0]  rd_in, rd_out, query_rd;
    logic [63:0] data_in, data_out;

    int total = 0;
    int bad   = 0;

    pipeline_mem_skid #(.DATA_W(64), .RD_W(4), .WEN_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wEn_in    (wEn_in),
        .rd_in     (rd_in),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wEn_out   (wEn_out),
        .rd_out    (rd_out),
        .data_out  (data_out),
        .occupancy (occupancy),
        .query_rd  (query_rd),
        .query_hit (query_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush, iv;
        logic [1:0]  wen;
        logic [3:0]  rd;
        logic [63:0] data;
        logic        ordy;
        logic [3:0]  qrd;
        logic        ov;
        logic [1:0]  wo;
        logic [3:0]  ro;
        logic [63:0] dout;
        logic [1:0]  occ;
        logic        ir, qh;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs[NV];

    function automatic vec_t mk(logic r, logic f, logic iv, logic [1:0] wen, logic [3:0] rd,
                                logic [63:0] data, logic ordy, logic [3:0] qrd, logic ov,
                                logic [1:0] wo, logic [3:0] ro, logic [63:0] dout,
                                logic [1:0] occ, logic ir, logic qh);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.wen = wen; v.rd = rd; v.data = data;
        v.ordy = ordy; v.qrd = qrd; v.ov = ov; v.wo = wo; v.ro = ro; v.dout = dout;
        v.occ = occ; v.ir = ir; v.qh = qh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    localparam logic [63:0] DA = 64'hA5A5_A5A5_A5A5_A5A5;

    logic [63:0] exp_q[$];
    logic [63:0] exp_front;
    int          sent;
    int          got;

    initial begin
        //          rst f iv wen rd  data   ordy q  | ov wo ro  dout   occ ir qh
        // reset held with input offered
        vecs[0]  = mk(1, 0, 1, 1, 3,  DA,    1, 0,   0, 0, 0,  0,     0, 1, 0);
        vecs[1]  = mk(1, 0, 1, 1, 3,  DA,    1, 0,   0, 0, 0,  0,     0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0,  0,     1, 0,   0, 0, 0,  0,     0, 1, 0);
        // streaming, 1-cycle latency
        vecs[3]  = mk(0, 0, 1, 1, 3,  DA,    1, 3,   1, 1, 3,  DA,    1, 1, 1);
        vecs[4]  = mk(0, 0, 1, 2, 7,  'h1234,1, 3,   1, 2, 7,  'h1234,1, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0,  0,     1, 7,   0, 0, 7,  'h1234,0, 1, 0);
        // back-pressure E1,E2,E3
        vecs[6]  = mk(0, 0, 1, 1, 1,  'h11,  0, 1,   1, 1, 1,  'h11,  1, 1, 1);
        vecs[7]  = mk(0, 0, 1, 2, 2,  'h22,  0, 2,   1, 1, 1,  'h11,  2, 0, 1);
        vecs[8]  = mk(0, 0, 1, 3, 3,  'h33,  0, 3,   1, 1, 1,  'h11,  2, 0, 0);
        vecs[9]  = mk(0, 0, 1, 3, 3,  'h33,  1, 3,   1, 2, 2,  'h22,  1, 1, 0);
        vecs[10] = mk(0, 0, 1, 3, 3,  'h33,  1, 3,   1, 3, 3,  'h33,  1, 1, 1);
        vecs[11] = mk(0, 0, 0, 0, 0,  0,     1, 3,   0, 0, 3,  'h33,  0, 1, 0);
        // flush from TWO, then flush beating an accept in ONE
        vecs[12] = mk(0, 0, 1, 1, 4,  'h44,  0, 4,   1, 1, 4,  'h44,  1, 1, 1);
        vecs[13] = mk(0, 0, 1, 1, 6,  'h66,  0, 6,   1, 1, 4,  'h44,  2, 0, 1);
        vecs[14] = mk(0, 1, 1, 3, 8,  'h88,  0, 6,   0, 0, 4,  'h44,  0, 1, 0);
        vecs[15] = mk(0, 0, 1, 1, 4,  'h45,  0, 4,   1, 1, 4,  'h45,  1, 1, 1);
        vecs[16] = mk(0, 1, 1, 3, 8,  'h88,  0, 8,   0, 0, 4,  'h45,  0, 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 0,  0,     1, 8,   0, 0, 4,  'h45,  0, 1, 0);
        // hazard query: main (1,5), skid (0,9)
        vecs[18] = mk(0, 0, 1, 1, 5,  'h55,  0, 5,   1, 1, 5,  'h55,  1, 1, 1);
        vecs[19] = mk(0, 0, 1, 0, 9,  'h99,  0, 5,   1, 1, 5,  'h55,  2, 0, 1);
        vecs[20] = mk(0, 0, 0, 0, 0,  0,     0, 9,   1, 1, 5,  'h55,  2, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0,  0,     0, 5,   1, 1, 5,  'h55,  2, 0, 1);
        vecs[22] = mk(0, 0, 0, 0, 0,  0,     1, 9,   1, 0, 9,  'h99,  1, 1, 0);
        vecs[23] = mk(0, 0, 0, 0, 0,  0,     1, 5,   0, 0, 9,  'h99,  0, 1, 0);
        // reset mid-operation in TWO, reset also beats a flush
        vecs[24] = mk(0, 0, 1, 1, 10, 'hA0,  0, 10,  1, 1, 10, 'hA0,  1, 1, 1);
        vecs[25] = mk(0, 0, 1, 1, 11, 'hB0,  0, 10,  1, 1, 10, 'hA0,  2, 0, 1);
        vecs[26] = mk(1, 1, 1, 2, 12, 'hC0,  1, 10,  0, 0, 0,  0,     0, 1, 0);
        vecs[27] = mk(0, 0, 1, 2, 12, 'hC0,  0, 12,  1, 2, 12, 'hC0,  1, 1, 1);
        vecs[28] = mk(0, 0, 0, 0, 0,  0,     1, 12,  0, 0, 12, 'hC0,  0, 1, 0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        wEn_in = '0; rd_in = '0; data_in = '0; query_rd = '0;

        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].iv;
            wEn_in = vecs[i].wen; rd_in = vecs[i].rd; data_in = vecs[i].data;
            out_ready = vecs[i].ordy; query_rd = vecs[i].qrd;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
            chk($sformatf("v%0d wEn_out", i),   64'(wEn_out),   64'(vecs[i].wo));
            chk($sformatf("v%0d rd_out", i),    64'(rd_out),    64'(vecs[i].ro));
            chk($sformatf("v%0d data_out", i),  data_out,       vecs[i].dout);
            chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(vecs[i].occ));
            chk($sformatf("v%0d in_ready", i),  64'(in_ready),  64'(vecs[i].ir));
            chk($sformatf("v%0d query_hit", i), 64'(query_hit), 64'(vecs[i].qh));
        end

        // Six entries under irregular back-pressure must emerge in order, none lost.
        rst = 1'b0; flush = 1'b0;
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            in_valid  = (sent < 6);
            wEn_in    = 2'd1;
            rd_in     = 4'(sent);
            data_in   = 64'h100 + 64'(sent);
            out_ready = ((cyc % 3) != 1);
            @(negedge clk);
            chk("stream occupancy", 64'(occupancy), 64'(exp_q.size()));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream spurious: got %0h expected no entry", data_out);
                end else begin
                    exp_front = exp_q.pop_front();
                    chk("stream order", data_out, exp_front);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(data_in);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        chk("stream count", 64'(got), 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_mem_skid.md
Name: pipeline_mem_skid

Overview:
Parametrised Memory-to-Writeback pipeline stage for the vector datapath. It carries the register-file write-enable, destination register index and 64-bit write data, with a valid/ready handshake and a 2-entry skid buffer, so Writeback back-pressure stalls the pipe without a combinational ready path. It also provides a synchronous flush and a destination-match query for hazard/forwarding logic.

Parameters:
DATA_W, 64, width of the write-data field
RD_W, 4, width of the destination register index
WEN_W, 2, width of the register-file write-enable field

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous flush: drops all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
wEn_in  in  WEN_W  write-enable of incoming entry
rd_in  in  RD_W  destination register of incoming entry
data_in  in  DATA_W  write data of incoming entry
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts the output entry
wEn_out  out  WEN_W  write-enable of output entry (gated)
rd_out  out  RD_W  destination register of output entry
data_out  out  DATA_W  write data of output entry
occupancy  out  2  entries held (0..2)
query_rd  in  RD_W  register index probed by hazard logic
query_hit  out  1  a held entry with nonzero write-enable targets query_rd

Behaviour:
- Reset and clock: one clock, clk. Reset rst is synchronous and active-high.
- Storage: a main register drives the outputs. A skid register holds a second entry. Each register has its own valid bit.
- State encoding: EMPTY (no entry), ONE (main only), TWO (main and skid). occupancy = 0/1/2 respectively.
- in_ready = (state != TWO). It depends on registered state only. There is no path from out_ready to in_ready.
- out_valid = (state != EMPTY). It is registered, with no combinational path from in_valid.
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Transitions:
  - EMPTY: on accept, main <= in and go to ONE.
  - ONE: accept with pop: main <= in, stay ONE. Accept without pop: skid <= in, go to TWO. Pop without accept: go to EMPTY. Otherwise hold.
  - TWO: accept is impossible. On pop, main <= skid and go to ONE. Otherwise hold.
- Ordering is strictly FIFO. No entry is dropped or duplicated except by flush or reset.
- Latency is 1 cycle: an entry accepted at edge N is presented with out_valid=1 after edge N.
- Throughput is 1 entry per cycle while out_ready=1.
- wEn_out = main_valid ? main_wEn : 0.
- rd_out and data_out hold their last loaded value when the stage is empty. Consumers qualify them with out_valid.
- Entries with wEn=0 (bubbles or stores) flow through like any other entry.
- query_hit is combinational. It is 1 if (main_valid && main_wEn!=0 && main_rd==query_rd) or (skid_valid && skid_wEn!=0 && skid_rd==query_rd).
- Flush: at the next edge both valid bits clear and state becomes EMPTY.
  - Flush beats accept in the same cycle: the input is dropped even though in_ready was 1.
  - A pop in the flush cycle still counts downstream.
- Reset:
  - Clears main and skid payloads to 0 and both valid bits, and sets state to EMPTY.
  - After reset: out_valid=0, wEn_out=0, rd_out=0, data_out=0, occupancy=0, in_ready=1, query_hit=0.
  - Reset beats flush and all handshakes.
  - Reset asserted mid-stream discards held entries with no partial writeback.
- Widths are fixed by the parameters. Payload is copied with no arithmetic.

Test Plan:
1. Reset behaviour: assert rst for 2 cycles with in_valid=1 -> out_valid=0, wEn_out=0, data_out=0, occupancy=0, in_ready=1 throughout reset and on the first cycle after it.
2. Streaming: out_ready=1, inject (wEn=1, rd=3, data=64'hA5A5...), then (2, 7, 64'h1234) on consecutive cycles -> each appears exactly 1 cycle later, in order, occupancy=1, in_ready stays 1.
3. Back-pressure: out_ready=0, inject entries E1, E2, E3 back-to-back.
   - Required: occupancy goes 1 then 2, and in_ready=0 after E2 is accepted.
   - E3 is held upstream until space frees.
   - Release out_ready -> outputs E1, E2, E3 in order with no loss.
4. Flush priority: with the stage in TWO, assert flush together with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, and the flushed-cycle input never appears.
5. Hazard query: hold entries (wEn=1, rd=5) in main and (wEn=0, rd=9) in skid.
   - query_rd=5 -> query_hit=1.
   - query_rd=9 -> query_hit=0.
   - After both entries drain -> query_hit=0.
6. Reset mid-operation: stage in TWO with out_ready=0, pulse rst for one cycle -> no held entry is ever presented, occupancy=0, and new input is accepted on the first cycle after reset with 1-cycle latency.
